// File: rtl/mips_imem_pkg.sv
// Shared types for the MIPS instruction-memory loader.
// Holds the FSM states, the reset-vector base and the address check.
package mips_imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

  // Word-aligned and inside [base, base+span).
  // Below-base addresses wrap to a huge offset and fail.
  function automatic logic addr_ok(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] span
  );
    return (addr[1:0] == 2'b00) &&
           ((addr - base) < span);
  endfunction

endpackage

// File: rtl/mips_imem_loader_if.sv
// Load and fetch bus between the test host / CPU and the loader.
// The loader owns instr_readdata; everything else flows into it.
interface mips_imem_loader_if;

  logic        init_mem;
  logic [31:0] init_mem_addr;
  logic [31:0] init_instr;
  logic        load_done;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;

  modport master (
    output init_mem,
    output init_mem_addr,
    output init_instr,
    output load_done,
    output instr_address,
    input  instr_readdata
  );

  modport slave (
    input  init_mem,
    input  init_mem_addr,
    input  init_instr,
    input  load_done,
    input  instr_address,
    output instr_readdata
  );

endinterface

// File: rtl/mips_imem_ram.sv
// Instruction storage: one synchronous write port, async read.
// A same-cycle write and read of one word returns the old word.
module mips_imem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_imem_loader.sv
// Loads a program image, holds the CPU in reset, then runs it
// until the CPU halts or the cycle budget expires.
module mips_imem_loader
  import mips_imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          RESET_HOLD  = 2,
  parameter int          TIMEOUT     = 500
) (
  input  logic        clk,
  input  logic        reset,
  mips_imem_loader_if.slave bus,
  output logic        cpu_reset,
  output logic        clk_enable,
  input  logic        cpu_active,
  output logic        halted,
  output logic        timed_out,
  output logic        load_error,
  output logic [15:0] load_count,
  output logic [31:0] cycle_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN =
    32'(4 * DEPTH_WORDS);
  localparam logic [31:0] LAST =
    32'(TIMEOUT - 1);
  localparam int HW =
    (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RESET_HOLD - 1);

  state_t        state;
  state_t        state_nx;
  logic [HW-1:0] hold_cnt;
  logic          seen_active;
  logic          load_en;
  logic          wr_ok;
  logic          wr_bad;
  logic          fetch_ok;
  logic          halt_hit;
  logic          time_hit;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [31:0]   ram_rdata;

  assign load_en  = bus.init_mem &&
                    (state == IDLE || state == LOAD);
  assign wr_ok    = load_en &&
    addr_ok(bus.init_mem_addr, BASE_ADDR, SPAN);
  assign wr_bad   = load_en && !wr_ok;
  assign fetch_ok =
    addr_ok(bus.instr_address, BASE_ADDR, SPAN);

  assign waddr =
    AW'((bus.init_mem_addr - BASE_ADDR) >> 2);
  assign raddr =
    AW'((bus.instr_address - BASE_ADDR) >> 2);

  // A drop of cpu_active only counts once the CPU has been seen up.
  assign halt_hit = (state == RUN) &&
                    seen_active && !cpu_active;
  assign time_hit = (state == RUN) &&
                    (cycle_count == LAST);

  assign cpu_reset  = (state == IDLE) ||
                      (state == LOAD) ||
                      (state == HOLD);
  assign clk_enable = (state == RUN);

  assign bus.instr_readdata =
    fetch_ok ? ram_rdata : 32'h0;

  mips_imem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok && !reset),
    .waddr(waddr),
    .wdata(bus.init_instr),
    .raddr(raddr),
    .rdata(ram_rdata)
  );

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.load_done) begin
          state_nx = HOLD;
        end else if (bus.init_mem) begin
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (bus.load_done) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (halt_hit || time_hit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counters and sticky flags; the cycle count keeps the
  // value seen in the final RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      seen_active <= 1'b0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
      load_error  <= 1'b0;
      load_count  <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_nx;
      if (wr_ok) begin
        load_count <= load_count + 16'd1;
      end
      if (wr_bad) begin
        load_error <= 1'b1;
      end
      if (state == HOLD) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (state == HOLD && state_nx == RUN) begin
        cycle_count <= '0;
        seen_active <= 1'b0;
      end
      if (state == RUN) begin
        if (cpu_active) begin
          seen_active <= 1'b1;
        end
        if (state_nx == RUN) begin
          cycle_count <= cycle_count + 32'd1;
        end
        if (halt_hit) begin
          halted <= 1'b1;
        end else if (time_hit) begin
          timed_out <= 1'b1;
        end
      end
    end
  end

endmodule
